// File: rtl/calc1_port_responder.sv
// CALC1 single-port responder: two-cycle command capture, in-order FIFO of
// pending commands, fixed-latency executor with registered response outputs.
module calc1_port_responder #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  reqcmd,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic [0:2]  outstanding,
  output logic        protocol_err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  localparam logic [0:0] S_IDLE = 1'b0, S_OP2  = 1'b1;
  localparam logic [0:0] E_IDLE = 1'b0, E_BUSY = 1'b1;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  // Returns {resp[1:0], data[31:0]}.
  function automatic logic [33:0] execute(entry_t e);
    logic [32:0] sum;
    sum = {1'b0, e.op1} + {1'b0, e.op2};
    case (e.cmd)
      4'd1:    execute = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
      4'd2:    execute = (e.op2 > e.op1) ? {2'd2, 32'd0} : {2'd1, e.op1 - e.op2};
      4'd5:    execute = {2'd1, e.op1 << e.op2[4:0]};
      4'd6:    execute = {2'd1, e.op1 >> e.op2[4:0]};
      default: execute = {2'd2, 32'd0};
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [0:0]    cap_q, cap_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   op1_q, op1_d;
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   fcnt_q, fcnt_d;
  logic [0:0]    ex_q, ex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        head_q, head_d;
  logic [1:0]    resp_q, resp_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    outs_q, outs_d;
  logic          perr_q, perr_d;
  logic          accept, push, pop, resp_now, slot_ok;
  entry_t        push_e;

  assign resp_now = (resp_q != 2'd0);
  // A response in this cycle frees its slot for a command arriving alongside it.
  assign slot_ok  = (outs_q < 3'(DEPTH)) || resp_now;
  assign push_e   = '{cmd: cmd_q, op1: op1_q, op2: req_data_in};

  always_comb begin
    cap_d  = cap_q;
    cmd_d  = cmd_q;
    op1_d  = op1_q;
    perr_d = perr_q;
    accept = 1'b0;
    push   = 1'b0;
    case (cap_q)
      S_IDLE: if (reqcmd != 4'd0) begin
        if (slot_ok) begin
          accept = 1'b1;
          cap_d  = S_OP2;
          cmd_d  = reqcmd;
          op1_d  = req_data_in;
        end else begin
          perr_d = 1'b1;
        end
      end
      default: begin
        push  = 1'b1;
        cap_d = S_IDLE;
        if (reqcmd != 4'd0) perr_d = 1'b1;
      end
    endcase

    ex_d   = ex_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    pop    = 1'b0;
    case (ex_q)
      E_IDLE: if (fcnt_q != '0) begin
        pop    = 1'b1;
        ex_d   = E_BUSY;
        cnt_d  = CW'(LATENCY - 1);
        head_d = fifo_q[rptr_q];
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) ex_d = E_IDLE;
      end
    endcase

    // Register the result so it is visible during the final busy cycle.
    resp_d = 2'd0;
    data_d = 32'd0;
    if (ex_d == E_BUSY && cnt_d == CW'(1)) {resp_d, data_d} = execute(head_d);

    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    fcnt_d = fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
    outs_d = outs_q + {2'b0, accept} - {2'b0, resp_now};
  end

  always_ff @(posedge c_clk) begin
    if (push) fifo_q[wptr_q] <= push_e;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap_q  <= S_IDLE;
      cmd_q  <= '0;
      op1_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      ex_q   <= E_IDLE;
      cnt_q  <= '0;
      head_q <= '0;
      resp_q <= '0;
      data_q <= '0;
      outs_q <= '0;
      perr_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      cmd_q  <= cmd_d;
      op1_q  <= op1_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
      ex_q   <= ex_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      resp_q <= resp_d;
      data_q <= data_d;
      outs_q <= outs_d;
      perr_q <= perr_d;
    end
  end

  assign out_resp     = resp_q;
  assign out_data     = data_q;
  assign outstanding  = outs_q;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: directed literal cases plus randomized
// traffic compared every cycle against a response-schedule model.
module tb_calc1_port_responder;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:3]  reqcmd;
  logic [0:31] data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic [0:2]  outstanding;
  logic        protocol_err;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  calc1_port_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .c_clk(clk), .reset(reset), .reqcmd(reqcmd), .req_data_in(data_in),
    .out_resp(out_resp), .out_data(out_data), .outstanding(outstanding),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic logic [33:0] ref_calc(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    longint s;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        ref_calc = (s > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, a + b};
      end
      4'd2:    ref_calc = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    ref_calc = {2'd1, a << (b % 32)};
      4'd6:    ref_calc = {2'd1, a >> (b % 32)};
      default: ref_calc = {2'd2, 32'd0};
    endcase
  endfunction

  // Model: each accepted command becomes a scheduled response at a known cycle.
  typedef struct { int rt; logic [1:0] r; logic [31:0] d; } rsp_t;
  rsp_t        mq[$];
  int          outs_m = 0, pt = 0, last_rt = -100;
  bit          perr_m = 1'b0, op2_pend = 1'b0;
  logic [3:0]  pcmd;
  logic [31:0] pop1;

  always @(negedge clk) begin
    logic [1:0]  er;
    logic [31:0] ed;
    logic [33:0] res;
    bit          rn, acc;
    rsp_t        r;
    cyc++;
    if (chk_en) begin
      er = 2'd0; ed = 32'd0;
      if (mq.size() > 0 && mq[0].rt == cyc) begin er = mq[0].r; ed = mq[0].d; end
      chk("model out_resp", 64'(out_resp), 64'(er));
      chk("model out_data", 64'(out_data), 64'(ed));
      chk("model outstanding", 64'(outstanding), 64'(outs_m));
      chk("model protocol_err", 64'(protocol_err), 64'(perr_m));
      if (reset) begin
        mq.delete(); outs_m = 0; perr_m = 1'b0; op2_pend = 1'b0; last_rt = -100;
      end else begin
        rn = (er != 2'd0);
        if (rn) void'(mq.pop_front());
        acc = 1'b0;
        if (op2_pend) begin
          res  = ref_calc(pcmd, pop1, data_in);
          r.rt = (pt + 1 + LAT > last_rt + LAT) ? pt + 1 + LAT : last_rt + LAT;
          r.r  = res[33:32];
          r.d  = res[31:0];
          mq.push_back(r);
          last_rt  = r.rt;
          op2_pend = 1'b0;
          if (reqcmd != 4'd0) perr_m = 1'b1;
        end else if (reqcmd != 4'd0) begin
          if (outs_m - int'(rn) < DEPTH) begin
            acc = 1'b1; op2_pend = 1'b1; pcmd = reqcmd; pop1 = data_in; pt = cyc;
          end else begin
            perr_m = 1'b1;
          end
        end
        outs_m = outs_m + int'(acc) - int'(rn);
      end
    end
  end

  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [3:0] c2,
                         input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                         input string nm);
    @(posedge clk); #1 reqcmd = c;  data_in = a;
    @(posedge clk); #1 reqcmd = c2; data_in = b;
    @(posedge clk); #1 reqcmd = 4'd0; data_in = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, " resp"}, 64'(out_resp), 64'(er));
    chk({nm, " data"}, 64'(out_data), 64'(ed));
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; reqcmd = 4'd0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  function automatic logic [3:0] pick_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'd1;
    if (r < 6) return 4'd2;
    if (r == 6) return 4'd5;
    if (r == 7) return 4'd6;
    return 4'($urandom_range(1, 15));
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 8));
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] prev;
    reset = 1'b1; reqcmd = 4'd0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset resp", 64'(out_resp), 64'd0);
    chk("reset data", 64'(out_data), 64'd0);
    chk("reset outstanding", 64'(outstanding), 64'd0);
    chk("reset perr", 64'(protocol_err), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // add 5+3 with cycle-exact timing
    @(posedge clk); #1 reqcmd = 4'd1; data_in = 32'd5;
    @(posedge clk); #1 reqcmd = 4'd0; data_in = 32'd3;
    @(negedge clk); chk("add T+1 outstanding", 64'(outstanding), 64'd1);
    @(posedge clk); #1 data_in = $urandom;
    @(posedge clk);
    @(negedge clk); chk("add T+3 resp", 64'(out_resp), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("add T+4 resp", 64'(out_resp), 64'd1);
    chk("add T+4 data", 64'(out_data), 64'h8);
    chk("add T+4 outstanding", 64'(outstanding), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("add T+5 resp", 64'(out_resp), 64'd0);
    chk("add T+5 outstanding", 64'(outstanding), 64'd0);
    repeat (2) @(posedge clk);

    run_cmd(4'd1, 32'hFFFF_FFFF, 4'd0, 32'h1,         2'd2, 32'h0,  "add ovf");
    run_cmd(4'd2, 32'd3,         4'd0, 32'd5,         2'd2, 32'h0,  "sub under");
    run_cmd(4'd2, 32'd5,         4'd0, 32'd5,         2'd1, 32'h0,  "sub equal");
    run_cmd(4'd2, 32'd9,         4'd0, 32'd4,         2'd1, 32'h5,  "sub 9-4");
    run_cmd(4'd5, 32'h1,         4'd0, 32'hFFFF_FFE4, 2'd1, 32'h10, "shl");
    run_cmd(4'd6, 32'h8000_0000, 4'd0, 32'd31,        2'd1, 32'h1,  "shr");
    run_cmd(4'd4, 32'h1234,      4'd0, 32'h1,         2'd2, 32'h0,  "cmd4");
    chk("perr still clear", 64'(protocol_err), 64'd0);
    run_cmd(4'd1, 32'd10,        4'd2, 32'd20,        2'd1, 32'd30, "op2 collision");
    chk("perr after collision", 64'(protocol_err), 64'd1);

    // sustained commands every 2 cycles eventually fill the port and drop one
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 reqcmd = pick_cmd(); data_in = pick_data();
      @(posedge clk); #1 reqcmd = 4'd0;       data_in = pick_data();
    end
    repeat (60) @(posedge clk);
    @(negedge clk); chk("perr after overflow drop", 64'(protocol_err), 64'd1);

    // reset with two commands in flight
    do_reset();
    @(posedge clk); #1 reqcmd = 4'd1; data_in = 32'd7;
    @(posedge clk); #1 reqcmd = 4'd0; data_in = 32'd8;
    @(posedge clk); #1 reqcmd = 4'd2; data_in = 32'd9;
    @(posedge clk); #1 reqcmd = 4'd0; data_in = 32'd1; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid reset resp", 64'(out_resp), 64'd0);
    chk("mid reset data", 64'(out_data), 64'd0);
    chk("mid reset outstanding", 64'(outstanding), 64'd0);
    chk("mid reset perr", 64'(protocol_err), 64'd0);
    repeat (10) @(posedge clk);

    // randomized phases: even phases obey command spacing, odd phases do not
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      prev = 4'd0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        if (ph % 2 == 0)
          reqcmd = (prev == 4'd0 && $urandom_range(0, 9) < 6) ? pick_cmd() : 4'd0;
        else
          reqcmd = ($urandom_range(0, 9) < 3) ? pick_cmd() : 4'd0;
        data_in = pick_data();
        prev = reqcmd;
      end
      @(posedge clk); #1 reqcmd = 4'd0;
      repeat (30) @(posedge clk);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
